ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit_pkg.sv | 24 ++
 rtl/ex_muldiv_unit_div_core.sv | 60 ++++++
 rtl/ex_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds the op encodings, the divide FSM states and the default iteration count.
package ex_muldiv_unit_pkg;

    localparam int DIV_STEPS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FIX    = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider on unsigned 32-bit magnitudes.
// Produces one quotient bit per cycle; last_step flags the cycle of the final iteration.
module div_core #(
    parameter int N_STEPS = ex_muldiv_unit_pkg::DIV_STEPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last_step
);

    localparam int CW = $clog2(N_STEPS);

    logic [31:0]   r_rem;
    logic [31:0]   r_quo;
    logic [31:0]   r_div;
    logic [CW-1:0] r_count;
    logic          r_active;

    logic [32:0]   w_shift;
    logic [32:0]   w_diff;
    logic          w_ge;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_diff    = w_shift - {1'b0, r_div};
    assign last_step = r_active && (r_count == CW'(N_STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= '0;
            r_quo    <= dividend;
            r_div    <= divisor;
            r_count  <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem   <= w_ge ? w_diff[31:0] : w_shift[31:0];
            r_quo   <= {r_quo[30:0], w_ge};
            r_count <= r_count + CW'(1);
            if (last_step) begin
                r_active <= 1'b0;
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: single-cycle multiply/MADD/MSUB/MTHI/MTLO and a
// multi-cycle divide with sign fix-up, flush and special-case handling.
module ex_muldiv_unit #(
    parameter int DIV_STEPS = ex_muldiv_unit_pkg::DIV_STEPS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);

    import ex_muldiv_unit_pkg::*;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic [31:0] r_a;
    logic        r_b_zero;
    logic        r_ovf;
    logic        r_neg_q;
    logic        r_neg_r;

    op_e         w_op;
    logic        w_busy;
    logic        w_accept;
    logic        w_is_div;
    logic        w_signed_div;
    logic        w_commit;
    logic [63:0] w_hilo;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_last_step;

    assign w_op         = op_e'(Op);
    assign w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_signed_div = (w_op == OP_DIV);
    assign w_accept     = Start && !w_busy && !Flush;
    assign w_hilo       = {r_hi, r_lo};

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    assign w_a_mag = (w_signed_div && A[31]) ? (32'd0 - A) : A;
    assign w_b_mag = (w_signed_div && B[31]) ? (32'd0 - B) : B;

    div_core #(
        .N_STEPS   (DIV_STEPS)
    ) u_div_core (
        .clk       (Clk),
        .rst       (Reset),
        .start     (w_accept && w_is_div),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .quotient  (w_quo),
        .remainder (w_rem),
        .last_step (w_last_step)
    );

    always_comb begin
        w_quo_fix = r_neg_q ? (32'd0 - w_quo) : w_quo;
        w_rem_fix = r_neg_r ? (32'd0 - w_rem) : w_rem;
        if (r_b_zero) begin
            w_quo_fix = 32'hFFFF_FFFF;
            w_rem_fix = r_a;
        end else if (r_ovf) begin
            w_quo_fix = 32'h8000_0000;
            w_rem_fix = 32'd0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = (r_state != ST_IDLE);
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_accept && w_is_div) w_state_next = ST_DIVIDE;
            ST_DIVIDE: if (w_last_step) w_state_next = ST_FIX;
            ST_FIX: begin
                w_state_next = ST_IDLE;
                w_commit     = !Flush;
            end
            default:   w_state_next = ST_IDLE;
        endcase
        if (Flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= (w_accept && !w_is_div) || w_commit;
            if (w_accept) begin
                case (w_op)
                    OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                    OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                    OP_MTHI:  r_hi <= A;
                    OP_MTLO:  r_lo <= A;
                    OP_MADD:  {r_hi, r_lo} <= w_hilo + w_prod_s;
                    OP_MSUB:  {r_hi, r_lo} <= w_hilo - w_prod_s;
                    default: begin
                        // Divide: latch what the fix-up cycle needs; magnitudes live in div_core.
                        r_a      <= A;
                        r_b_zero <= (B == 32'd0);
                        r_ovf    <= w_signed_div && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
                        r_neg_q  <= w_signed_div && (A[31] ^ B[31]);
                        r_neg_r  <= w_signed_div && A[31];
                    end
                endcase
            end else if (w_commit) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign Busy = w_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus queues expected {HI,LO};
// a monitor pops and compares on every Done pulse.
module tb_ex_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    ex_muldiv_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Flush (Flush),
        .HI    (HI),
        .LO    (LO),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        sb_q.push_back(e);
        exp_hi = hi;
        exp_lo = lo;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Operands are scrambled right after the accepting edge to prove they were captured.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        A     = 32'hA5A5_5A5A;
        B     = 32'h5A5A_A5A5;
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(name, 64'(n), 64'(exp_cycles));
    endtask

    task automatic run_div(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        expect_result(name, hi, lo);
        issue(op, a, b);
        wait_idle({name, "_busy_cycles"}, 33);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual HI=%h LO=%h required no Done", HI, LO);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_hi"}, 64'(HI), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(LO), 64'(e.lo));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        Reset = 1'b1;
        Start = 1'b0;
        Flush = 1'b0;
        Op    = 3'b000;
        A     = 32'd0;
        B     = 32'd0;
        #2;
        chk("reset_hi",   64'(HI),   64'd0);
        chk("reset_lo",   64'(LO),   64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        tick();
        tick();
        Reset = 1'b0;

        // Single-cycle ops, first one on the first edge after reset release.
        expect_result("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy", 64'(Busy), 64'd0);
        expect_result("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("mthi", 32'h0000_0000, 32'h0000_0001);
        issue(OP_MTHI, 32'd0, 32'd99);
        expect_result("mtlo", 32'h0000_0000, 32'h0000_0005);
        issue(OP_MTLO, 32'd5, 32'd99);
        expect_result("madd", 32'h0000_0000, 32'h0000_0019);
        issue(OP_MADD, 32'd4, 32'd5);
        expect_result("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        issue(OP_MSUB, 32'd30, 32'd1);
        expect_result("madd_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        issue(OP_MADD, 32'hFFFF_FFFF, 32'd2);

        run_div("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_100_0",   OP_DIVU, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
        run_div("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_div("divu_max_16",  OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
        run_div("div_7_m2",     OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_div("div_m7_m2",    OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003);
        run_div("div_m7_0",     OP_DIV,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Start while busy must be ignored.
        expect_result("divu_9_2", 32'h0000_0001, 32'h0000_0004);
        issue(OP_DIVU, 32'd9, 32'd2);
        Start = 1'b1;
        Op    = OP_MTLO;
        A     = 32'h0000_0777;
        tick();
        Start = 1'b0;
        wait_idle("busy_start_cycles", 32);

        // Flush in cycle 10 of a divide.
        issue(OP_DIVU, 32'd50, 32'd7);
        repeat (9) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_hi",   64'(HI),   64'(exp_hi));
        chk("flush_lo",   64'(LO),   64'(exp_lo));
        repeat (40) tick();
        chk("flush_late_lo", 64'(LO), 64'(exp_lo));

        // Start and Flush together: nothing issues.
        Start = 1'b1;
        Flush = 1'b1;
        Op    = OP_MTLO;
        A     = 32'h0000_DEAD;
        tick();
        Op    = OP_DIVU;
        A     = 32'd8;
        B     = 32'd2;
        tick();
        Start = 1'b0;
        Flush = 1'b0;
        chk("start_flush_busy", 64'(Busy), 64'd0);
        chk("start_flush_lo",   64'(LO),   64'(exp_lo));
        repeat (3) tick();

        // Flush during the fix-up cycle suppresses the write.
        issue(OP_DIVU, 32'd20, 32'd3);
        repeat (32) tick();
        chk("fix_busy", 64'(Busy), 64'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("fix_flush_busy", 64'(Busy), 64'd0);
        chk("fix_flush_hi",   64'(HI),   64'(exp_hi));
        chk("fix_flush_lo",   64'(LO),   64'(exp_lo));
        repeat (3) tick();

        // Asynchronous reset at cycle 20 of a divide.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (19) tick();
        Reset = 1'b1;
        #1;
        chk("rst_mid_hi",   64'(HI),   64'd0);
        chk("rst_mid_lo",   64'(LO),   64'd0);
        chk("rst_mid_busy", 64'(Busy), 64'd0);
        chk("rst_mid_done", 64'(Done), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick();
        Reset = 1'b0;
        expect_result("mtlo_after_reset", 32'h0000_0000, 32'h0000_1234);
        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        repeat (40) tick();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
